// File: rtl/comp42_row_pipe.sv
// ---------------------------------------------------------------------------
// comp42_row_pipe
//   A row of WIDTH 4:2 compressor columns for partial-product reduction.
//   Four WIDTH-bit operands are reduced to a Sum/Carry pair. A final add then
//   forms the WIDTH+2 bit Result. Column carries chain from LSB to MSB. When
//   Mode=1, the low APPROX_LSB columns switch to a carry-free approximate cell.
//   The row sits behind a two-stage valid/ready pipeline:
//   S1 holds the compressor outputs, and S2 holds the outputs plus Result.
//
// Ports
//   clk, rst_n        clock (rising edge) and async active-low reset
//   In_valid/In_ready input handshake; In_ready is combinational
//   X1..X4            operands, sampled with the beat
//   Mode              0 = exact, 1 = approximate low columns
//   Out_valid/Out_ready output handshake
//   Sum, Carry, Cout  S2 copy of the compressor vectors
//                     Carry bit i has weight 2^(i+1); Cout has weight 2^WIDTH
//   Result            Sum + (Carry<<1) + (Cout<<WIDTH)
// ---------------------------------------------------------------------------
module comp42_row_pipe #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned APPROX_LSB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] X2,
    input  logic [WIDTH-1:0] X3,
    input  logic [WIDTH-1:0] X4,
    input  logic             Mode,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic [WIDTH-1:0] Carry,
    output logic             Cout,
    output logic [WIDTH+1:0] Result
);

    // Combinational compressor row
    logic [WIDTH-1:0] row_sum;
    logic [WIDTH-1:0] row_carry;
    logic             row_cout;

    always_comb begin
        logic chain;
        logic s;
        logic co;
        row_sum   = '0;
        row_carry = '0;
        chain     = 1'b0;
        s         = 1'b0;
        co        = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (Mode && (i < APPROX_LSB)) begin
                // The approximate cell neither uses nor produces a chained carry.
                row_sum[i]   = (X1[i] ^ X2[i]) | (X3[i] ^ X4[i]);
                row_carry[i] = (X1[i] & X2[i]) | (X3[i] & X4[i]);
                co           = 1'b0;
            end else begin
                s            = X1[i] ^ X2[i] ^ X3[i];
                co           = (X1[i] & X2[i]) | (X1[i] & X3[i]) | (X2[i] & X3[i]);
                row_sum[i]   = s ^ X4[i] ^ chain;
                row_carry[i] = (s & X4[i]) | (s & chain) | (X4[i] & chain);
            end
            chain = co;
        end
        row_cout = chain;
    end

    // Pipeline registers
    logic             s1_v_q,     s1_v_d;
    logic [WIDTH-1:0] s1_sum_q,   s1_carry_q;
    logic             s1_cout_q;
    logic             s2_v_q,     s2_v_d;
    logic [WIDTH-1:0] s2_sum_q,   s2_carry_q;
    logic             s2_cout_q;
    logic [WIDTH+1:0] s2_result_q, s2_result_d;
    logic             s1_en;
    logic             s2_en;

    always_comb begin
        s2_en  = s1_v_q & (~s2_v_q | Out_ready);
        s1_en  = ~s1_v_q | s2_en;
        // When S1 may load, its valid flag simply follows the input.
        s1_v_d = s1_en ? In_valid : s1_v_q;
        if (s2_en) begin
            s2_v_d = 1'b1;
        end else if (Out_ready) begin
            s2_v_d = 1'b0;
        end else begin
            s2_v_d = s2_v_q;
        end
        s2_result_d = {2'b00, s1_sum_q}
                    + {1'b0, s1_carry_q, 1'b0}
                    + {1'b0, s1_cout_q, {WIDTH{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_sum_q    <= '0;
            s1_carry_q  <= '0;
            s1_cout_q   <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_sum_q    <= '0;
            s2_carry_q  <= '0;
            s2_cout_q   <= 1'b0;
            s2_result_q <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            if (s1_en && In_valid) begin
                s1_sum_q   <= row_sum;
                s1_carry_q <= row_carry;
                s1_cout_q  <= row_cout;
            end
            if (s2_en) begin
                s2_sum_q    <= s1_sum_q;
                s2_carry_q  <= s1_carry_q;
                s2_cout_q   <= s1_cout_q;
                s2_result_q <= s2_result_d;
            end
        end
    end

    assign In_ready  = s1_en;
    assign Out_valid = s2_v_q;
    assign Sum       = s2_sum_q;
    assign Carry     = s2_carry_q;
    assign Cout      = s2_cout_q;
    assign Result    = s2_result_q;

endmodule
